n2_ex_arb: RTL and testbench
============================

N2_EX_ARB -- requirements
Module: n2_ex_arb

Interface
REQ-001 SHALL have parameter LAT, default 1: fixed shared-ALU latency in cycles; legal values 1 and 2.
REQ-002 SHALL have parameter PW, default 64: width of the per-lane operand payload ({op1,op2}).
REQ-003 SHALL have ports clk (input, 1): the single clock. resetn (input, 1): asynchronous, active-low reset.
REQ-004 SHALL have ports req_v_i (input, 2) and req_rdy_o (output, 2): per-lane request valid/ready; lane0 is always the older instruction.
REQ-005 SHALL have ports req_uid_i (input, 2x8) and req_pl_i (input, 2xPW): per-lane uid and payload.
REQ-006 SHALL have ports ex_v_o (output, 1), ex_uid_o (output, 8) and ex_pl_o (output, PW): issue to the shared ALU.
REQ-007 SHALL have ports ex_done_i (input, 1) and ex_rst_i (input, 32): ALU result, valid exactly LAT cycles after issue.
REQ-008 SHALL have ports rsp_v_o (output, 2), rsp_uid_o (output, 8) and rsp_rst_o (output, 32): result routed to the originating lane.
REQ-009 SHALL have ports stall_i (input, 1): writeback back-pressure, blocks new issue. flush_i (input, 1): kill pending and in-flight.
REQ-010 SHALL have port err_o (output, 1): sticky protocol-error flag.

Function
REQ-011 SHALL implement a 2-state arbiter FSM: FREE and L1_PEND.
REQ-012 In FREE with !stall_i && !flush_i, arbitration SHALL be:
  - only lane0 valid: grant lane0.
  - only lane1 valid: grant lane1.
  - both valid: grant lane0 and go to L1_PEND.
REQ-013 In L1_PEND with !stall_i && !flush_i, the FSM SHALL grant lane1 only, ignore lane0, and return to FREE.
REQ-014 At most one grant SHALL occur per cycle, and lane1 SHALL never be granted while an older lane0 request is valid and ungranted.
REQ-015 Grant SHALL be combinational: req_rdy_o[i]=1 exactly in the cycle lane i is granted; a transfer occurs on req_v_i[i]&&req_rdy_o[i].
REQ-016 On a transfer, ex_v_o, ex_uid_o and ex_pl_o SHALL be registered and driven the next cycle; ex_v_o=0 otherwise.
REQ-017 The block SHALL track in-flight ops in a LAT-deep shift register of {valid, lane, uid}, advanced every cycle regardless of stall_i.
REQ-018 When ex_done_i=1 and the tracker tail is valid, the block SHALL drive the following in the same cycle (combinational):
  - rsp_v_o[lane]=1.
  - rsp_uid_o = tracked uid.
  - rsp_rst_o = ex_rst_i.
REQ-019 When ex_done_i=1 and the tail is invalid, or the tail is valid and ex_done_i=0, the block SHALL set err_o=1, sticky until reset; such a result SHALL be dropped.
REQ-020 stall_i=1 SHALL force req_rdy_o=0 and hold the FSM state; in-flight results SHALL still return.
REQ-021 flush_i=1 SHALL:
  - force req_rdy_o=0.
  - return the FSM to FREE.
  - clear all tracker valid bits next cycle.
  - clear ex_v_o next cycle.
  Results for flushed ops SHALL be dropped without setting err_o.
REQ-022 After a flush_i pulse, err_o checking SHALL be suppressed for the next LAT cycles.
REQ-023 Throughput SHALL be one issue per cycle with no bubble between back-to-back grants, including the lane0-then-lane1 pair.
REQ-024 A lane1 request that drops in L1_PEND (upstream bug) SHALL return the FSM to FREE without granting and set err_o.

Reset
REQ-025 When resetn=0 (asynchronous), the block SHALL hold:
  - FSM=FREE.
  - tracker valids=0.
  - ex_v_o=0.
  - err_o=0.
  - rsp_v_o=0 and req_rdy_o=0.
REQ-026 ex_uid_o, ex_pl_o and tracker uid/lane SHALL be don't-care after reset.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight ops; results arriving after deassertion with empty tracker SHALL set err_o.

Verification
REQ-028 Single request, LAT=1: lane0 uid=0x11 valid one cycle, ex_rst_i=0x5 -> req_rdy_o=01 that cycle, ex_v_o=1 next cycle, then rsp_v_o=01, rsp_uid_o=0x11, rsp_rst_o=0x5.
REQ-029 Dual issue, LAT=2: both lanes valid at cycle 0 (uid 0x20 lane0, 0x21 lane1) -> rdy=01 at c0, rdy=10 at c1, ex_uid_o 0x20 at c1 and 0x21 at c2, rsp_v_o=01 at c3 and 10 at c4.
REQ-030 Stall: both lanes valid, stall_i=1 for 3 cycles -> no rdy and FSM held, then identical sequence to REQ-029 after release.
REQ-031 Flush: issue uid 0x30, flush_i at next cycle with LAT=2 -> rsp_v_o stays 00, err_o stays 0, FSM=FREE.
REQ-032 Protocol error: ex_done_i=1 with empty tracker -> err_o=1 next cycle and stays 1 until resetn=0.
REQ-033 Reset mid-flight: issue uid 0x40, pulse resetn low before the result returns -> all outputs 0 immediately, no rsp for 0x40.

Source files
------------

// File: rtl/n2_ex_arb.sv
`default_nettype none
// ============================================================================
//  Module   : n2_ex_arb
//  Purpose  : Two-lane issue arbiter in front of a shared fixed-latency ALU.
//             Lane0 always holds the older instruction. When both lanes
//             request in the same cycle, lane0 is granted first and lane1 is
//             granted the next cycle, with no bubble. A LAT-deep tracker
//             records {valid, lane, uid} for every issued op so the ALU
//             result can be routed back to the lane that sent it.
//  Ports    : clk, resetn          - clock, asynchronous active-low reset
//             req_v_i/req_rdy_o    - per-lane request valid / combinational grant
//             req_uid_i/req_pl_i   - per-lane uid and operand payload
//             ex_v_o/ex_uid_o/ex_pl_o - registered issue to the shared ALU
//             ex_done_i/ex_rst_i   - ALU result, LAT cycles after issue
//             rsp_v_o/rsp_uid_o/rsp_rst_o - result routed to its origin lane
//             stall_i              - blocks new issue (results still return)
//             flush_i              - kills pending and in-flight ops
//             err_o                - sticky protocol-error flag
//  Revision : 1.0 - initial release
// ============================================================================
module n2_ex_arb #(
    parameter int LAT = 1,
    parameter int PW  = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [1:0]          req_v_i,
    output logic [1:0]          req_rdy_o,
    input  logic [1:0][7:0]     req_uid_i,
    input  logic [1:0][PW-1:0]  req_pl_i,
    output logic                ex_v_o,
    output logic [7:0]          ex_uid_o,
    output logic [PW-1:0]       ex_pl_o,
    input  logic                ex_done_i,
    input  logic [31:0]         ex_rst_i,
    output logic [1:0]          rsp_v_o,
    output logic [7:0]          rsp_uid_o,
    output logic [31:0]         rsp_rst_o,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic                err_o
);

    localparam logic [0:0] c_FREE    = 1'b0;
    localparam logic [0:0] c_L1_PEND = 1'b1;
    localparam logic [1:0] c_SUP     = 2'(LAT);

    logic [0:0]           state_q, state_d;
    logic [1:0]           gnt;
    logic                 drop_err;
    logic                 xfer;
    logic                 w_lane;

    logic                 ex_v_q;
    logic                 ex_lane_q;
    logic [7:0]           ex_uid_q;
    logic [PW-1:0]        ex_pl_q;

    logic [LAT-1:0]       trk_v_q;
    logic [LAT-1:0]       trk_lane_q;
    logic [LAT-1:0][7:0]  trk_uid_q;

    logic [1:0]           sup_q;
    logic                 err_q, err_d;
    logic                 tail_v;
    logic                 rsp_fire;
    logic                 proto_err;

    // Arbitration. The grant only ever names a lane that is valid, so the
    // grant vector doubles as the transfer indication.
    always_comb begin
        state_d  = state_q;
        gnt      = 2'b00;
        drop_err = 1'b0;
        if (flush_i) begin
            state_d = c_FREE;
        end else if (!stall_i) begin
            case (state_q)
                c_FREE: begin
                    if (req_v_i[0]) begin
                        gnt = 2'b01;
                        if (req_v_i[1]) begin
                            state_d = c_L1_PEND;
                        end
                    end else if (req_v_i[1]) begin
                        gnt = 2'b10;
                    end
                end
                c_L1_PEND: begin
                    // Lane1 was promised this slot; a withdrawn lane1 request
                    // is an upstream bug, so give up the slot and flag it.
                    state_d = c_FREE;
                    if (req_v_i[1]) begin
                        gnt = 2'b10;
                    end else begin
                        drop_err = 1'b1;
                    end
                end
                default: state_d = c_FREE;
            endcase
        end
    end

    assign xfer      = |gnt;
    assign w_lane    = gnt[1];
    // Gating with resetn keeps the grant low while the block is held in reset.
    assign req_rdy_o = resetn ? gnt : 2'b00;

    assign tail_v    = trk_v_q[LAT-1];
    // A result arriving in the flush cycle belongs to a killed op.
    assign rsp_fire  = ex_done_i & tail_v & ~flush_i;
    // Errors are masked in the flush cycle and the LAT cycles after it, when
    // results of flushed ops may still come back from the ALU.
    assign proto_err = ~flush_i & (sup_q == 2'd0) & (ex_done_i ^ tail_v);
    assign err_d     = err_q | proto_err | drop_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= c_FREE;
            ex_v_q     <= 1'b0;
            ex_lane_q  <= 1'b0;
            ex_uid_q   <= '0;
            ex_pl_q    <= '0;
            trk_v_q    <= '0;
            trk_lane_q <= '0;
            trk_uid_q  <= '0;
            sup_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ex_v_q  <= xfer;
            if (xfer) begin
                ex_lane_q <= w_lane;
                ex_uid_q  <= req_uid_i[w_lane];
                ex_pl_q   <= req_pl_i[w_lane];
            end
            // Tracker entry 0 follows the issue stage, so the tail lines up
            // with the ALU result exactly LAT cycles after ex_v_o.
            trk_v_q[0]    <= ex_v_q & ~flush_i;
            trk_lane_q[0] <= ex_lane_q;
            trk_uid_q[0]  <= ex_uid_q;
            for (int k = 1; k < LAT; k++) begin
                trk_v_q[k]    <= trk_v_q[k-1] & ~flush_i;
                trk_lane_q[k] <= trk_lane_q[k-1];
                trk_uid_q[k]  <= trk_uid_q[k-1];
            end
            if (flush_i) begin
                sup_q <= c_SUP;
            end else if (sup_q != 2'd0) begin
                sup_q <= sup_q - 2'd1;
            end
            err_q <= err_d;
        end
    end

    assign ex_v_o    = ex_v_q;
    assign ex_uid_o  = ex_uid_q;
    assign ex_pl_o   = ex_pl_q;
    assign rsp_v_o   = rsp_fire ? (trk_lane_q[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_uid_o = rsp_fire ? trk_uid_q[LAT-1] : 8'h00;
    assign rsp_rst_o = rsp_fire ? ex_rst_i : 32'h0;
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_n2_ex_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n2_ex_arb
//  Purpose  : Self-checking bench for n2_ex_arb. Two instances (LAT=1 and
//             LAT=2) share the request side; each has its own ALU model.
//             Expectations come from a cycle-indexed timeline model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_n2_ex_arb;

    localparam int N = 4096;

    logic               clk = 1'b0;
    logic               resetn = 1'b1;
    logic [1:0]         req_v = '0;
    logic [1:0][7:0]    req_uid = '0;
    logic [1:0][63:0]   req_pl = '0;
    logic               stall = 1'b0;
    logic               flush = 1'b0;
    logic               ex_done [2];
    logic [31:0]        ex_rst  [2];

    logic [1:0]         rdy  [2];
    logic               exv  [2];
    logic [7:0]         exu  [2];
    logic [63:0]        expl [2];
    logic [1:0]         rspv [2];
    logic [7:0]         rspu [2];
    logic [31:0]        rspr [2];
    logic               err  [2];

    always #5 clk = ~clk;

    n2_ex_arb #(.LAT(1), .PW(64)) u_dut_l1 (
        .clk(clk), .resetn(resetn),
        .req_v_i(req_v), .req_rdy_o(rdy[0]), .req_uid_i(req_uid), .req_pl_i(req_pl),
        .ex_v_o(exv[0]), .ex_uid_o(exu[0]), .ex_pl_o(expl[0]),
        .ex_done_i(ex_done[0]), .ex_rst_i(ex_rst[0]),
        .rsp_v_o(rspv[0]), .rsp_uid_o(rspu[0]), .rsp_rst_o(rspr[0]),
        .stall_i(stall), .flush_i(flush), .err_o(err[0])
    );

    n2_ex_arb #(.LAT(2), .PW(64)) u_dut_l2 (
        .clk(clk), .resetn(resetn),
        .req_v_i(req_v), .req_rdy_o(rdy[1]), .req_uid_i(req_uid), .req_pl_i(req_pl),
        .ex_v_o(exv[1]), .ex_uid_o(exu[1]), .ex_pl_o(expl[1]),
        .ex_done_i(ex_done[1]), .ex_rst_i(ex_rst[1]),
        .rsp_v_o(rspv[1]), .rsp_uid_o(rspu[1]), .rsp_rst_o(rspr[1]),
        .stall_i(stall), .flush_i(flush), .err_o(err[1])
    );

    // ---------------- reference model state ----------------
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lf    = 0;
    bit          have_lf = 1'b0;
    bit          owed  = 1'b0;     // lane1 promised the next free slot
    bit          exp_err [2];
    bit          inj   = 1'b0;     // inject a spurious ALU result this cycle
    bit          use_fix = 1'b0;
    logic [31:0] fix_rst = 32'h0;

    bit          alu_v   [2][N];
    logic [31:0] alu_rst [2][N];
    logic [1:0]  exp_rv  [2][N];
    logic [7:0]  exp_ru  [2][N];
    bit          exp_exv [N];
    logic [7:0]  exp_exu [N];
    logic [63:0] exp_expl[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cyc%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: called right after a falling edge with the request
    // inputs already set; checks at +2, updates the model, moves on.
    task automatic step();
        logic [1:0] er;
        bit         ln;
        bit         supp;
        bit         errn;
        bit         exp_any;
        for (int d = 0; d < 2; d++) begin
            if (inj) alu_v[d][cyc] = 1'b1;
            ex_done[d] = alu_v[d][cyc];
            ex_rst[d]  = alu_rst[d][cyc];
        end
        if (flush) begin
            for (int d = 0; d < 2; d++)
                for (int t = cyc; t < N; t++) exp_rv[d][t] = 2'b00;
        end
        #2;
        er = 2'b00;
        if (!stall && !flush) begin
            if (owed)            er = {req_v[1], 1'b0};
            else if (req_v[0])   er = 2'b01;
            else if (req_v[1])   er = 2'b10;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rdy[L%0d]", d + 1), rdy[d], er);
            chk($sformatf("ex_v[L%0d]", d + 1), exv[d], exp_exv[cyc]);
            if (exp_exv[cyc]) begin
                chk($sformatf("ex_uid[L%0d]", d + 1), exu[d], exp_exu[cyc]);
                chk($sformatf("ex_pl[L%0d]", d + 1), expl[d], exp_expl[cyc]);
            end
            chk($sformatf("rsp_v[L%0d]", d + 1), rspv[d], exp_rv[d][cyc]);
            if (exp_rv[d][cyc] != 2'b00) begin
                chk($sformatf("rsp_uid[L%0d]", d + 1), rspu[d], exp_ru[d][cyc]);
                chk($sformatf("rsp_rst[L%0d]", d + 1), rspr[d], alu_rst[d][cyc]);
            end
            chk($sformatf("err[L%0d]", d + 1), err[d], exp_err[d]);
            // ALU model answers whatever the DUT actually issued.
            if (exv[d] === 1'b1) begin
                alu_v[d][cyc + d + 1]   = 1'b1;
                alu_rst[d][cyc + d + 1] = use_fix ? fix_rst : $urandom;
            end
        end
        if (er != 2'b00) begin
            ln = er[1];
            exp_exv[cyc + 1]  = 1'b1;
            exp_exu[cyc + 1]  = req_uid[ln];
            exp_expl[cyc + 1] = req_pl[ln];
            for (int d = 0; d < 2; d++) begin
                exp_rv[d][cyc + 2 + d] = er;
                exp_ru[d][cyc + 2 + d] = req_uid[ln];
            end
        end
        if (flush) begin
            lf = cyc;
            have_lf = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            supp    = flush || (have_lf && (cyc - lf) >= 1 && (cyc - lf) <= d + 1);
            exp_any = (exp_rv[d][cyc] != 2'b00);
            errn    = !supp && (alu_v[d][cyc] != exp_any);
            if (!stall && !flush && owed && !req_v[1]) errn = 1'b1;
            if (errn) exp_err[d] = 1'b1;
        end
        if (flush)                                   owed = 1'b0;
        else if (!stall && owed)                     owed = 1'b0;
        else if (!stall && req_v[0] && req_v[1])     owed = 1'b1;
        inj = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset pulse lasting ncyc cycles, asserted mid-cycle.
    task automatic do_reset(input int ncyc);
        for (int d = 0; d < 2; d++) begin
            ex_done[d] = alu_v[d][cyc];
            ex_rst[d]  = alu_rst[d][cyc];
        end
        #2 resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_rdy[L%0d]", d + 1), rdy[d], 2'b00);
            chk($sformatf("rst_ex_v[L%0d]", d + 1), exv[d], 1'b0);
            chk($sformatf("rst_rsp_v[L%0d]", d + 1), rspv[d], 2'b00);
            chk($sformatf("rst_err[L%0d]", d + 1), err[d], 1'b0);
            exp_err[d] = 1'b0;
            for (int t = 0; t < N; t++) begin
                exp_rv[d][t] = 2'b00;
                if (d == 0) exp_exv[t] = 1'b0;
            end
        end
        owed = 1'b0;
        have_lf = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cyc++;
        end
        resetn = 1'b1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] u0, input logic [7:0] u1,
                         input bit s, input bit f);
        req_v      = v;
        req_uid[0] = u0;
        req_uid[1] = u1;
        req_pl[0]  = {$urandom, $urandom};
        req_pl[1]  = {$urandom, $urandom};
        stall      = s;
        flush      = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ex_done[d] = 1'b0;
            ex_rst[d]  = 32'h0;
            exp_err[d] = 1'b0;
            for (int t = 0; t < N; t++) begin
                alu_v[d][t]   = 1'b0;
                alu_rst[d][t] = 32'h0;
                exp_rv[d][t]  = 2'b00;
                exp_ru[d][t]  = 8'h00;
            end
        end
        for (int t = 0; t < N; t++) begin
            exp_exv[t]  = 1'b0;
            exp_exu[t]  = 8'h00;
            exp_expl[t] = 64'h0;
        end
        @(negedge clk);
        req_v = 2'b11;              // grants must still be held off in reset
        do_reset(2);
        idle(2);

        // Single request, result 0x5
        use_fix = 1'b1;
        fix_rst = 32'h5;
        drive(2'b01, 8'h11, 8'h00, 1'b0, 1'b0); step();
        idle(4);
        use_fix = 1'b0;

        // Dual issue: lane0 then lane1 back to back
        drive(2'b11, 8'h20, 8'h21, 1'b0, 1'b0); step();
        drive(2'b10, 8'h00, 8'h21, 1'b0, 1'b0); step();
        idle(4);

        // Stall holds both requests for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 8'h20, 8'h21, 1'b1, 1'b0); step();
        end
        drive(2'b11, 8'h20, 8'h21, 1'b0, 1'b0); step();
        drive(2'b10, 8'h00, 8'h21, 1'b0, 1'b0); step();
        idle(4);

        // Stall while lane1 is pending, then release
        drive(2'b11, 8'h22, 8'h23, 1'b0, 1'b0); step();
        drive(2'b11, 8'h24, 8'h23, 1'b1, 1'b0); step();
        drive(2'b11, 8'h24, 8'h23, 1'b0, 1'b0); step();
        idle(4);

        // Flush right after an issue: result dropped, no error
        drive(2'b01, 8'h30, 8'h00, 1'b0, 1'b0); step();
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1); step();
        idle(4);

        // Flush while lane1 is pending returns the arbiter to FREE
        drive(2'b11, 8'h31, 8'h32, 1'b0, 1'b0); step();
        drive(2'b11, 8'h33, 8'h32, 1'b0, 1'b1); step();
        drive(2'b11, 8'h33, 8'h32, 1'b0, 1'b0); step();
        drive(2'b10, 8'h00, 8'h32, 1'b0, 1'b0); step();
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive(2'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom % 5) == 0, ($urandom % 25) == 0);
            if (owed) req_v[1] = 1'b1;
            step();
        end
        idle(4);

        // Reset mid-flight: stale result after release is a protocol error
        drive(2'b01, 8'h40, 8'h00, 1'b0, 1'b0); step();
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0); step();
        do_reset(1);
        idle(4);
        do_reset(1);
        idle(2);

        // Spurious ALU result with an empty tracker: sticky error
        inj = 1'b1;
        idle(1);
        idle(4);
        do_reset(1);
        idle(2);

        // Lane1 withdrawn while pending
        drive(2'b11, 8'h50, 8'h51, 1'b0, 1'b0); step();
        drive(2'b01, 8'h52, 8'h00, 1'b0, 1'b0); step();
        idle(4);
        do_reset(1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
